// File: rtl/gci_irq_arbiter.sv
// GCI interrupt arbiter: per-node enable/mode gating, optional rising-edge pending latch,
// priority pick with lowest-index tie-break, and a VALID/ACK handshake toward the core.
`default_nettype none

module gci_irq_arbiter #(
  parameter int P_NODE_N  = 8,
  parameter int P_PRI_W   = 8,
  parameter int P_ENTRY_W = 5,
  parameter int P_NUM_W   = 6
) (
  input  logic                          iCLOCK,
  input  logic                          inRESET,
  input  logic                          iIRQ_CTRL_REQ,
  input  logic [P_ENTRY_W-1:0]          iIRQ_CTRL_ENTRY,
  input  logic                          iIRQ_CTRL_INFO_MASK,
  input  logic                          iIRQ_CTRL_INFO_VALID,
  input  logic [1:0]                    iIRQ_CTRL_INFO_MODE,
  input  logic                          iNODEINF_VALID,
  input  logic [P_NODE_N*P_PRI_W-1:0]   iNODE_PRIORITY,
  input  logic [P_NODE_N-1:0]           iNODE_IRQ,
  output logic [P_NODE_N-1:0]           oNODE_ACK,
  output logic                          oNODE_IRQ_BUSY,
  output logic                          oIRQ_EMPTY,
  output logic                          oIRQ_VALID,
  output logic [P_NUM_W-1:0]            oIRQ_NUM,
  input  logic                          iIRQ_ACK
);

  typedef enum logic {
    IDLE     = 1'b0,
    ACK_WAIT = 1'b1
  } stateT;

  stateT                 state;
  stateT                 stateNext;

  logic [P_NODE_N-1:0]   entValid;
  logic [P_NODE_N-1:0]   entMask;
  logic [1:0]            entMode [P_NODE_N];
  logic [P_NODE_N-1:0]   pending;
  logic [P_NODE_N-1:0]   irqPrev;

  logic [P_NODE_N-1:0]   ctrlHit;
  logic [P_NODE_N-1:0]   nodeEn;
  logic [P_NODE_N-1:0]   edgeMode;
  logic [P_NODE_N-1:0]   rise;
  logic [P_NODE_N-1:0]   req;
  logic [P_NODE_N-1:0]   grantVec;

  logic                  winAny;
  logic                  winFound;
  logic [P_NUM_W-1:0]    winIdx;
  logic [P_PRI_W-1:0]    winPri;
  logic                  grant;
  logic [P_NUM_W-1:0]    irqNum;

  // Per-node gating; an out-of-range control index simply matches no node
  always_comb begin
    ctrlHit  = '0;
    nodeEn   = '0;
    edgeMode = '0;
    rise     = '0;
    req      = '0;
    for (int i = 0; i < P_NODE_N; i++) begin
      ctrlHit[i]  = iIRQ_CTRL_REQ && (iIRQ_CTRL_ENTRY == P_ENTRY_W'(i));
      nodeEn[i]   = !entValid[i] || entMask[i];
      edgeMode[i] = (entMode[i] == 2'b01);
      rise[i]     = iNODE_IRQ[i] && !irqPrev[i];
      req[i]      = nodeEn[i] && (edgeMode[i] ? pending[i] : iNODE_IRQ[i]);
    end
  end

  // Strict greater-than keeps the lowest index on equal priority
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    winPri   = '0;
    for (int i = 0; i < P_NODE_N; i++) begin
      if (req[i] && (!winFound || (iNODE_PRIORITY[i*P_PRI_W +: P_PRI_W] > winPri))) begin
        winFound = 1'b1;
        winPri   = iNODE_PRIORITY[i*P_PRI_W +: P_PRI_W];
        winIdx   = P_NUM_W'(i);
      end
    end
    winAny = |req;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    grant      = 1'b0;
    oIRQ_VALID = 1'b0;
    case (state)
      IDLE: begin
        if (winAny && iNODEINF_VALID) begin
          grant     = 1'b1;
          stateNext = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        oIRQ_VALID = 1'b1;
        if (iIRQ_ACK) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    grantVec = '0;
    for (int i = 0; i < P_NODE_N; i++) begin
      grantVec[i] = grant && (winIdx == P_NUM_W'(i));
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      irqNum <= '0;
    end else if (grant) begin
      irqNum <= winIdx + P_NUM_W'(1);
    end
  end

  // A rise coinciding with a grant re-arms the latch; a control write always wins
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      pending <= '0;
      irqPrev <= '0;
    end else begin
      pending <= ((pending & ~grantVec) | (rise & nodeEn & edgeMode)) & ~ctrlHit;
      irqPrev <= iNODE_IRQ;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      entValid <= '0;
      entMask  <= '0;
      for (int i = 0; i < P_NODE_N; i++) begin
        entMode[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < P_NODE_N; i++) begin
        if (ctrlHit[i]) begin
          entValid[i] <= iIRQ_CTRL_INFO_VALID;
          entMask[i]  <= iIRQ_CTRL_INFO_MASK;
          entMode[i]  <= iIRQ_CTRL_INFO_MODE;
        end
      end
    end
  end

  assign oNODE_ACK      = grantVec;
  assign oNODE_IRQ_BUSY = !iNODEINF_VALID;
  assign oIRQ_EMPTY     = (state == IDLE) && !winAny;
  assign oIRQ_NUM       = irqNum;

endmodule

`default_nettype wire
